// File: rtl/reaction_timer_if.sv
// Handshake bundle between the button logic, the reaction-timer controller and
// the 7-segment display mux.
interface reaction_timer_if;
    logic       start;
    logic       stop;
    logic       clear;
    logic       led;
    logic [7:0] in3;
    logic [7:0] in2;
    logic [7:0] in1;
    logic [7:0] in0;

    modport master (
        output start, stop, clear,
        input  led, in3, in2, in1, in0
    );

    modport slave (
        input  start, stop, clear,
        output led, in3, in2, in1, in0
    );
endinterface

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer game controller: random pre-stimulus delay, millisecond BCD
// timing of the player's response, and segment patterns for the display mux.
module reaction_timer_ctrl #(
    parameter int TICK_DIV     = 100000,
    parameter int MIN_DELAY_MS = 2000,
    parameter int RAND_BITS    = 12
) (
    input  logic              clk,
    input  logic              reset,
    reaction_timer_if.slave   bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(MIN_DELAY_MS + (1 << RAND_BITS) + 1);

    localparam logic [7:0]  SEG_BLANK = 8'hFF;
    localparam logic [7:0]  SEG_H     = 8'h89;
    localparam logic [7:0]  SEG_I     = 8'hCF;
    localparam logic [7:0]  SEG_DASH  = 8'hBF;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_TIMING = 3'd2,
        S_DONE   = 3'd3,
        S_EARLY  = 3'd4
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c && (r[4*i +: 4] == 4'd9)) begin
                r[4*i +: 4] = 4'd0;
            end else if (c) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                c = 1'b0;
            end else begin
                c = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    state_t         state_q, state_d;
    logic [15:0]    lfsr_q;
    logic [TW-1:0]  tick_q, tick_d;
    logic [DW-1:0]  delay_q, delay_d;
    logic [15:0]    bcd_q, bcd_d;
    logic           led_q, led_d;
    logic [7:0]     seg3_q, seg2_q, seg1_q, seg0_q;
    logic [7:0]     seg3_d, seg2_d, seg1_d, seg0_d;
    logic           tick_s;

    assign tick_s = (tick_q == TW'(TICK_DIV - 1));

    // Next-state, delay and BCD count; clear outranks stop, which outranks start.
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        bcd_d   = bcd_q;
        case (state_q)
            S_IDLE: begin
                if (bus.clear) begin
                    state_d = S_IDLE;
                end else if (bus.start) begin
                    state_d = S_WAIT;
                    delay_d = DW'(MIN_DELAY_MS) + DW'(lfsr_q[RAND_BITS-1:0]);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (bus.clear) begin
                    state_d = S_IDLE;
                end else if (bus.stop) begin
                    state_d = S_EARLY;
                end else if (tick_s) begin
                    delay_d = delay_q - DW'(1);
                    // A zero load would otherwise wrap into a very long wait.
                    if (delay_q <= DW'(1)) begin
                        state_d = S_TIMING;
                        bcd_d   = 16'h0000;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_TIMING: begin
                if (bus.clear) begin
                    state_d = S_IDLE;
                end else if (bus.stop) begin
                    state_d = S_DONE;
                end else if (bcd_q == 16'h9999) begin
                    state_d = S_DONE;
                end else if (tick_s) begin
                    bcd_d = bcd_inc(bcd_q);
                    if (bcd_q == 16'h9998) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_TIMING;
                    end
                end else begin
                    state_d = S_TIMING;
                end
            end
            S_DONE, S_EARLY: begin
                if (bus.clear) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Millisecond tick divider, restarted whenever the state changes.
    always_comb begin
        tick_d = tick_q;
        if (state_d != state_q) begin
            tick_d = '0;
        end else if (tick_s) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + TW'(1);
        end
    end

    // Display patterns and LED derived from the current state and count.
    always_comb begin
        led_d  = 1'b0;
        seg3_d = SEG_BLANK;
        seg2_d = SEG_BLANK;
        seg1_d = SEG_H;
        seg0_d = SEG_I;
        case (state_q)
            S_IDLE: begin
                seg1_d = SEG_H;
                seg0_d = SEG_I;
            end
            S_WAIT: begin
                seg1_d = SEG_BLANK;
                seg0_d = SEG_BLANK;
            end
            S_TIMING, S_DONE: begin
                led_d  = (state_q == S_TIMING);
                seg3_d = seg_encode(bcd_q[15:12]) & 8'h7F;
                seg2_d = seg_encode(bcd_q[11:8]);
                seg1_d = seg_encode(bcd_q[7:4]);
                seg0_d = seg_encode(bcd_q[3:0]);
            end
            S_EARLY: begin
                seg3_d = SEG_DASH;
                seg2_d = SEG_DASH;
                seg1_d = SEG_DASH;
                seg0_d = SEG_DASH;
            end
            default: begin
                led_d = 1'b0;
            end
        endcase
    end

    // State, counters, LFSR and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            tick_q  <= '0;
            delay_q <= '0;
            bcd_q   <= 16'h0000;
            led_q   <= 1'b0;
            seg3_q  <= SEG_BLANK;
            seg2_q  <= SEG_BLANK;
            seg1_q  <= SEG_H;
            seg0_q  <= SEG_I;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_next(lfsr_q);
            tick_q  <= tick_d;
            delay_q <= delay_d;
            bcd_q   <= bcd_d;
            led_q   <= led_d;
            seg3_q  <= seg3_d;
            seg2_q  <= seg2_d;
            seg1_q  <= seg1_d;
            seg0_q  <= seg0_d;
        end
    end

    assign bus.led = led_q;
    assign bus.in3 = seg3_q;
    assign bus.in2 = seg2_q;
    assign bus.in1 = seg1_q;
    assign bus.in0 = seg0_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl with shortened tick and delay settings.
module tb_reaction_timer_ctrl;

    localparam int TD  = 4;
    localparam int MIN = 3;
    localparam int RB  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    reaction_timer_if bus ();

    reaction_timer_ctrl #(
        .TICK_DIV     (TD),
        .MIN_DELAY_MS (MIN),
        .RAND_BITS    (RB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] m_lfsr;

    // Reference LFSR tracking the value the controller samples on start.
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input logic l,
                            input logic [7:0] e3, input logic [7:0] e2,
                            input logic [7:0] e1, input logic [7:0] e0);
        check_eq(tag, {31'd0, bus.led, bus.in3, bus.in2, bus.in1, bus.in0},
                      {31'd0, l, e3, e2, e1, e0});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        step();
    endtask

    // Start a trial and count edges (start edge included) until the LED rises.
    task automatic start_and_wait(output int n, output int d);
        d = MIN + int'(m_lfsr[RB-1:0]);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n = 1;
        while (bus.led !== 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    int n;
    int d;
    int seen;

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.clear = 1'b0;
        reset     = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk_disp("reset_vals", 1'b0, 8'hFF, 8'hFF, 8'h89, 8'hCF);
        check_eq("reset_lfsr", {48'd0, dut.lfsr_q}, 64'hACE1);
        for (int i = 0; i < 50; i++) begin
            step();
            chk_disp("idle_hold", 1'b0, 8'hFF, 8'hFF, 8'h89, 8'hCF);
        end

        // Normal trial: five ticks after the LED rises.
        start_and_wait(n, d);
        check_eq("norm_latency", n, 4*d + 2);
        chk_disp("timing_zero", 1'b1, 8'h40, 8'hC0, 8'hC0, 8'hC0);
        repeat (20) step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        step();
        chk_disp("norm_result", 1'b0, 8'h40, 8'hC0, 8'hC0, 8'h92);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b1;
        step();
        bus.stop  = 1'b0;
        repeat (10) step();
        chk_disp("norm_hold", 1'b0, 8'h40, 8'hC0, 8'hC0, 8'h92);
        pulse_clear();
        chk_disp("norm_clear", 1'b0, 8'hFF, 8'hFF, 8'h89, 8'hCF);

        // Delay range over several trials with varying idle gaps.
        for (int t = 0; t < 8; t++) begin
            repeat (t + 1) step();
            start_and_wait(n, d);
            check_eq("delay_pred", n, 4*d + 2);
            check_eq("delay_range", {63'd0, (n >= 4*MIN + 2) && (n <= 4*(MIN + 3) + 2)}, 64'd1);
            pulse_clear();
        end

        // Early press after two ticks.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk_disp("wait_blank", 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        repeat (7) step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        step();
        chk_disp("early_dash", 1'b0, 8'hBF, 8'hBF, 8'hBF, 8'hBF);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk_disp("early_start_ign", 1'b0, 8'hBF, 8'hBF, 8'hBF, 8'hBF);
        seen = 0;
        repeat (40) begin
            step();
            if (bus.led === 1'b1) seen = 1;
        end
        check_eq("early_no_led", seen, 0);
        pulse_clear();
        chk_disp("early_clear", 1'b0, 8'hFF, 8'hFF, 8'h89, 8'hCF);

        // Saturation: no stop, count runs to 9.999.
        start_and_wait(n, d);
        check_eq("sat_latency", n, 4*d + 2);
        n = 0;
        while (bus.led === 1'b1 && n < 45000) begin
            step();
            n++;
        end
        check_eq("sat_cycles", n, 39996);
        chk_disp("sat_display", 1'b0, 8'h10, 8'h90, 8'h90, 8'h90);
        repeat (20) step();
        chk_disp("sat_hold", 1'b0, 8'h10, 8'h90, 8'h90, 8'h90);
        pulse_clear();
        chk_disp("sat_clear", 1'b0, 8'hFF, 8'hFF, 8'h89, 8'hCF);

        // Stop and clear together during timing: clear wins.
        start_and_wait(n, d);
        repeat (6) step();
        bus.stop  = 1'b1;
        bus.clear = 1'b1;
        step();
        bus.stop  = 1'b0;
        bus.clear = 1'b0;
        step();
        chk_disp("stop_clear_idle", 1'b0, 8'hFF, 8'hFF, 8'h89, 8'hCF);
        repeat (20) step();
        chk_disp("stop_clear_hold", 1'b0, 8'hFF, 8'hFF, 8'h89, 8'hCF);

        // Reset in the middle of the wait phase.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        chk_disp("pre_reset_wait", 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        reset = 1'b1;
        step();
        chk_disp("mid_reset_vals", 1'b0, 8'hFF, 8'hFF, 8'h89, 8'hCF);
        check_eq("mid_reset_lfsr", {48'd0, dut.lfsr_q}, 64'hACE1);
        reset = 1'b0;
        repeat (30) step();
        chk_disp("post_reset_idle", 1'b0, 8'hFF, 8'hFF, 8'h89, 8'hCF);
        start_and_wait(n, d);
        check_eq("post_reset_delay", n, 4*d + 2);
        pulse_clear();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
